// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state encoding and the core-side response record.
// No logic and no latency; the response helper is purely combinational.
// Backpressure is not applicable here.
package apb_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

  // An abort (ready low) always reports an error with zero data; write responses never carry data.
  function automatic apb_rsp_t make_rsp(
    input logic                      ready,
    input logic                      slverr,
    input logic                      write,
    input logic [APB_DATA_WIDTH-1:0] prdata
  );
    apb_rsp_t r;
    r.err   = ready ? slverr : 1'b1;
    r.rdata = (ready && !write) ? prdata : '0;
    return r;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Watchdog for APB ACCESS wait states: counts enabled cycles and flags the last allowed one.
// The hit output is combinational from the count and the enable; a clear takes priority over counting.
// No backpressure; TIMEOUT_CYCLES of 0 disables the hit output entirely.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          ARMED = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT = ARMED ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] count;

  assign hit = ARMED && en && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_req_master.sv
// APB3 initiator: turns a req/gnt/rvalid core port into SETUP/ACCESS transfers.
// Grant to rvalid is 3 cycles with zero wait states, plus one per PREADY-low cycle.
// gnt_o stalls the core while a transfer is in flight; back-to-back grants land on the completing cycle.
module apb_req_master
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_mst_state_e state;
  apb_rsp_t       rsp_q;
  logic           in_access;
  logic           timeout_hit;
  logic           done;

  assign in_access = (state == ACCESS);
  assign done      = in_access && (PREADY || timeout_hit);
  assign gnt_o     = req_i && ((state == IDLE) || done);

  assign rdata_o = rsp_q.rdata;
  assign err_o   = rsp_q.err;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .clr  (gnt_o || done),
    .en   (in_access && !PREADY),
    .hit  (timeout_hit)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      rvalid_o <= 1'b0;
      rsp_q    <= '0;
    end else begin
      rvalid_o <= done;
      if (done) begin
        rsp_q <= make_rsp(PREADY, PSLVERR, PWRITE, PRDATA);
      end

      // A grant wins over the ACCESS exit so a completing transfer chains straight into SETUP.
      if (gnt_o) begin
        state   <= SETUP;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE  <= we_i;
        PADDR   <= addr_i;
        PWDATA  <= wdata_i;
      end else begin
        case (state)
          SETUP: begin
            state   <= ACCESS;
            PENABLE <= 1'b1;
          end
          ACCESS: begin
            if (done) begin
              state   <= IDLE;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with a 4-cycle watchdog; inputs change and outputs are
// checked 1 time unit after each rising edge, with expected values written out per step.
module tb_apb_req_master;

  logic        HCLK;
  logic        HRESETn;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total;
  int bad;

  apb_req_master #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic sel, input logic en);
    chk({tag, "_psel"}, {31'd0, PSEL}, {31'd0, sel});
    chk({tag, "_penable"}, {31'd0, PENABLE}, {31'd0, en});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    HRESETn = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    PRDATA  = '0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;

    #12;
    chk_bus("rst", 1'b0, 1'b0);
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_paddr", {20'd0, PADDR}, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    step();
    HRESETn = 1'b1;
    step();

    // Zero-wait write
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h010; wdata_i = 32'hDEADBEEF;
    #1;
    chk("w0_gnt", {31'd0, gnt_o}, 32'd1);
    step();
    req_i = 1'b0;
    chk_bus("w0_c1", 1'b1, 1'b0);
    chk("w0_paddr", {20'd0, PADDR}, 32'h010);
    chk("w0_pwdata", PWDATA, 32'hDEADBEEF);
    chk("w0_pwrite", {31'd0, PWRITE}, 32'd1);
    step();
    chk_bus("w0_c2", 1'b1, 1'b1);
    chk("w0_c2_rvalid", {31'd0, rvalid_o}, 32'd0);
    step();
    chk("w0_c3_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("w0_c3_err", {31'd0, err_o}, 32'd0);
    chk("w0_c3_rdata", rdata_o, 32'd0);
    chk_bus("w0_c3", 1'b0, 1'b0);
    step();
    chk("w0_c4_rvalid", {31'd0, rvalid_o}, 32'd0);

    // Read with three wait states
    PREADY = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h020; wdata_i = 32'h0;
    step();
    req_i = 1'b0; addr_i = 12'hFFF;
    chk_bus("r3_c1", 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_bus($sformatf("r3_c%0d", c), 1'b1, 1'b1);
      chk($sformatf("r3_c%0d_paddr", c), {20'd0, PADDR}, 32'h020);
      chk($sformatf("r3_c%0d_rvalid", c), {31'd0, rvalid_o}, 32'd0);
    end
    step();
    PREADY = 1'b1; PRDATA = 32'h12345678;
    chk_bus("r3_c5", 1'b1, 1'b1);
    chk("r3_c5_paddr", {20'd0, PADDR}, 32'h020);
    step();
    chk("r3_c6_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("r3_c6_rdata", rdata_o, 32'h12345678);
    chk("r3_c6_err", {31'd0, err_o}, 32'd0);
    chk_bus("r3_c6", 1'b0, 1'b0);

    // Slave error on a read
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h030;
    step();
    req_i = 1'b0;
    step();
    PSLVERR = 1'b1; PRDATA = 32'h0000CAFE;
    step();
    PSLVERR = 1'b0;
    chk("se_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("se_err", {31'd0, err_o}, 32'd1);
    chk("se_rdata", rdata_o, 32'h0000CAFE);

    // Watchdog abort after four ACCESS cycles
    PREADY = 1'b0; PRDATA = 32'h55;
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h040;
    step();
    req_i = 1'b0;
    chk_bus("to_c1", 1'b1, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk_bus($sformatf("to_c%0d", c), 1'b1, 1'b1);
      chk($sformatf("to_c%0d_rvalid", c), {31'd0, rvalid_o}, 32'd0);
    end
    step();
    chk_bus("to_c6", 1'b0, 1'b0);
    chk("to_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("to_err", {31'd0, err_o}, 32'd1);
    chk("to_rdata", rdata_o, 32'd0);
    PREADY = 1'b1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h044; wdata_i = 32'hA5A5A5A5;
    step();
    req_i = 1'b0;
    step();
    step();
    chk("to_next_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("to_next_err", {31'd0, err_o}, 32'd0);
    chk("to_next_rdata", rdata_o, 32'd0);

    // Back-to-back zero-wait writes
    step();
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h000; wdata_i = 32'h1;
    #1;
    chk("bb_c0_gnt", {31'd0, gnt_o}, 32'd1);
    step();
    addr_i = 12'h004; wdata_i = 32'h2;
    #1;
    chk("bb_c1_gnt", {31'd0, gnt_o}, 32'd0);
    chk_bus("bb_c1", 1'b1, 1'b0);
    step();
    chk_bus("bb_c2", 1'b1, 1'b1);
    chk("bb_c2_paddr", {20'd0, PADDR}, 32'h000);
    chk("bb_c2_gnt", {31'd0, gnt_o}, 32'd1);
    step();
    req_i = 1'b0;
    chk_bus("bb_c3", 1'b1, 1'b0);
    chk("bb_c3_paddr", {20'd0, PADDR}, 32'h004);
    chk("bb_c3_pwdata", PWDATA, 32'h2);
    chk("bb_c3_rvalid", {31'd0, rvalid_o}, 32'd1);
    step();
    chk_bus("bb_c4", 1'b1, 1'b1);
    chk("bb_c4_rvalid", {31'd0, rvalid_o}, 32'd0);
    step();
    chk("bb_c5_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk_bus("bb_c5", 1'b0, 1'b0);

    // Reset asserted mid-ACCESS with PREADY low
    PREADY = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h080;
    step();
    req_i = 1'b0;
    step();
    chk_bus("rm_access", 1'b1, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_bus("rm_async", 1'b0, 1'b0);
    chk("rm_async_rvalid", {31'd0, rvalid_o}, 32'd0);
    step();
    step();
    HRESETn = 1'b1;
    PREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rm_post%0d_rvalid", c), {31'd0, rvalid_o}, 32'd0);
      chk_bus($sformatf("rm_post%0d", c), 1'b0, 1'b0);
    end
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h084;
    #1;
    chk("rm_idle_gnt", {31'd0, gnt_o}, 32'd1);
    step();
    req_i = 1'b0;
    step();
    step();
    chk("rm_after_rvalid", {31'd0, rvalid_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
